// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: size encodings, the
// response entry layout and the byte-lane merge helper.
package data_sram_responder_pkg;

  // Encodings of data_sram_size. The responder does not act on them.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Countdown field width; LATENCY tops out at 8, so the countdown is at most 7.
  localparam int CD_W = 3;

  // Response payload stored per queue entry: store flag plus sampled word.
  typedef struct packed {
    logic        wr;
    logic [31:0] word;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  // Replace the byte lanes of old_word selected by strb with lanes of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_chk.sv
// Simulation-only property checks for the data SRAM responder.
module data_sram_responder_chk
  import data_sram_responder_pkg::*;
#(
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input logic             clk,
  input logic             resetn,
  input logic             req,
  input logic [1:0]       size,
  input logic             data_ok,
  input logic [CNT_W-1:0] count
);

  a_params_legal: assert property (@(posedge clk)
    (LATENCY >= 32'sd1) && (LATENCY <= 32'sd8) &&
    (MAX_OUTSTANDING >= 32'sd1) && (MAX_OUTSTANDING <= 32'sd4));

  a_no_retire_when_empty: assert property (@(posedge clk) disable iff (!resetn)
    data_ok |-> (count != {CNT_W{1'b0}}));

  a_size_legal: assert property (@(posedge clk) disable iff (!resetn)
    req |-> ((size == SIZE_BYTE) || (size == SIZE_HALF) || (size == SIZE_WORD)));

endmodule

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response queue. Each entry carries a payload and a countdown
// that starts at LATENCY-1; the head is ready once its countdown is zero.
module resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int W       = 33,
  parameter int LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic                         head_ready,
  output logic [W-1:0]                 head_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(LATENCY - 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [CD_W-1:0]  cd_q   [DEPTH];
  logic [CD_W-1:0]  cd_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  assign head_ready = valid_q[head_q] && (cd_q[head_q] == {CD_W{1'b0}});
  assign head_data  = data_q[head_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;

  // Next state: age all entries, retire the head, then append at the tail so
  // a full queue that retires and accepts in one cycle reuses the freed slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cd_d    = cd_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cd_q[i] != {CD_W{1'b0}})) begin
        cd_d[i] = cd_q[i] - CD_W'(1'b1);
      end else begin
        cd_d[i] = cd_q[i];
      end
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      data_d[tail_q]  = push_data;
      cd_d[tail_q]    = CD_LOAD;
      tail_d          = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state: reset discards every in-flight entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= {DEPTH{1'b0}};
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        cd_q[i] <= {CD_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cd_q    <= cd_d;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the data SRAM bus: word RAM with byte-strobed
// stores, load data sampled at acceptance and returned in order after LATENCY.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int RAM_DEPTH = 32'd1 << ADDR_WIDTH;

  logic [31:0]           ram_q [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  accept_s;
  logic                  store_s;
  logic                  head_ready_s;
  logic                  full_s;
  logic [CNT_W-1:0]      count_s;
  resp_t                 push_s;
  resp_t                 head_s;
  logic                  unused_s;

  // Upper address bits alias and the byte offset never selects a word.
  assign idx_s    = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_s = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  // A retiring head frees a slot in the same cycle, so a full queue still accepts.
  assign data_sram_addr_ok = ~full_s | head_ready_s;
  assign accept_s          = data_sram_req & data_sram_addr_ok;
  assign store_s           = accept_s & data_sram_wr & resetn;

  // Loads capture the word now, so later stores cannot change the response.
  assign push_s.wr   = data_sram_wr;
  assign push_s.word = ram_q[idx_s];

  // Response outputs come straight from the head entry's flops.
  assign data_sram_data_ok = head_ready_s;
  assign data_sram_rdata   = (head_ready_s && !head_s.wr) ? head_s.word : 32'd0;

  // Stores commit at the acceptance edge; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (store_s) begin
      ram_q[idx_s] <= merge_lanes(ram_q[idx_s], data_sram_wdata, data_sram_wstrb);
    end
  end

  resp_queue #(
    .DEPTH   (MAX_OUTSTANDING),
    .W       (RESP_W),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept_s),
    .push_data  (push_s),
    .pop        (head_ready_s),
    .head_ready (head_ready_s),
    .head_data  (head_s),
    .full       (full_s),
    .count      (count_s)
  );

  data_sram_responder_chk #(
    .LATENCY         (LATENCY),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_chk (
    .clk     (clk),
    .resetn  (resetn),
    .req     (data_sram_req),
    .size    (data_sram_size),
    .data_ok (data_sram_data_ok),
    .count   (count_s)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: instance a runs LATENCY=1, instance b runs LATENCY=3, both
// with two outstanding entries. Expected responses are queued at issue time.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, a_req, a_wr, a_addr_ok, a_data_ok;
  logic [1:0]  a_size;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        rstn_b, b_req, b_wr, b_addr_ok, b_data_ok;
  logic [1:0]  b_size;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] model_a[int];
  logic [31:0] model_b[int];

  data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(1), .MAX_OUTSTANDING(2)) dut_a (
    .clk(clk), .resetn(rstn_a), .data_sram_req(a_req), .data_sram_wr(a_wr),
    .data_sram_size(a_size), .data_sram_wstrb(a_wstrb), .data_sram_addr(a_addr),
    .data_sram_wdata(a_wdata), .data_sram_addr_ok(a_addr_ok),
    .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_rdata)
  );

  data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .resetn(rstn_b), .data_sram_req(b_req), .data_sram_wr(b_wr),
    .data_sram_size(b_size), .data_sram_wstrb(b_wstrb), .data_sram_addr(b_addr),
    .data_sram_wdata(b_wdata), .data_sram_addr_ok(b_addr_ok),
    .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_rdata)
  );

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Scoreboard: every retired response is compared with the oldest expectation.
  logic [31:0] ea, eb;
  always @(negedge clk) begin
    if (a_data_ok === 1'b1) begin
      total++;
      assert (exp_a.size() != 0) else begin
        bad++; $error("FAIL a_unexpected_resp observed=data_ok expected=no_response");
      end
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        total++;
        assert (a_rdata === ea) else begin
          bad++; $error("FAIL a_rdata observed=%08h expected=%08h", a_rdata, ea);
        end
      end
    end
    if (b_data_ok === 1'b1) begin
      total++;
      assert (exp_b.size() != 0) else begin
        bad++; $error("FAIL b_unexpected_resp observed=data_ok expected=no_response");
      end
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        total++;
        assert (b_rdata === eb) else begin
          bad++; $error("FAIL b_rdata observed=%08h expected=%08h", b_rdata, eb);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++; $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Drive one request, wait (bounded) for addr_ok, queue its expected response.
  task automatic issue(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    logic ok;
    int idx;
    logic [31:0] cur;
    if (sel) begin
      b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
    end else begin
      a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && ok !== 1'b1; i++) begin
      @(negedge clk);
      ok = sel ? b_addr_ok : a_addr_ok;
    end
    chk(sel ? "b_accept" : "a_accept", {31'd0, ok}, 32'd1);
    idx = int'(addr[13:2]);
    if (sel) cur = model_b.exists(idx) ? model_b[idx] : 32'd0;
    else     cur = model_a.exists(idx) ? model_a[idx] : 32'd0;
    if (wr) begin
      if (sel) begin model_b[idx] = lane_merge(cur, wdata, wstrb); exp_b.push_back(32'd0); end
      else     begin model_a[idx] = lane_merge(cur, wdata, wstrb); exp_a.push_back(32'd0); end
    end else begin
      if (sel) exp_b.push_back(cur);
      else     exp_a.push_back(cur);
    end
    @(posedge clk); #1;
    if (sel) b_req = 1'b0;
    else     a_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
    chk("drain", exp_a.size() + exp_b.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_size = 2'd2; a_wstrb = 4'h0; a_addr = 32'd0; a_wdata = 32'd0;
    b_req = 1'b0; b_wr = 1'b0; b_size = 2'd2; b_wstrb = 4'h0; b_addr = 32'd0; b_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1; rstn_a = 1'b1; rstn_b = 1'b1;

    // Reset/idle state for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_addr_ok", {31'd0, a_addr_ok}, 32'd1);
      chk("idle_data_ok", {31'd0, a_data_ok}, 32'd0);
      chk("idle_rdata", a_rdata, 32'd0);
    end
    chk("b_reset_addr_ok", {31'd0, b_addr_ok}, 32'd1);
    chk("b_reset_data_ok", {31'd0, b_data_ok}, 32'd0);
    @(posedge clk); #1;

    // Full-word store then load of the same word via a non-zero byte offset.
    issue(1'b0, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'hF);
    issue(1'b0, 1'b0, 32'h0000_0102, 32'd0, 4'h0);
    drain();

    // Byte-lane store, a zero-strobe store, then load.
    issue(1'b0, 1'b1, 32'h0000_0100, 32'h0000_1100, 4'h2);
    issue(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'h0);
    issue(1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'h0);
    drain();
    chk("merge_const", model_a[int'(32'h40)], 32'hAABB_11DD);

    // LATENCY=1: response in the cycle right after acceptance.
    issue(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'h0);
    @(negedge clk);
    chk("lat1_data_ok", {31'd0, a_data_ok}, 32'd1);
    drain();

    // Upper address bits alias.
    issue(1'b0, 1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'd0, 4'h0);
    issue(1'b0, 1'b0, 32'h8000_0013, 32'd0, 4'h0);
    drain();

    // Preload instance b.
    issue(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF);
    issue(1'b1, 1'b1, 32'h0000_0024, 32'h2222_2222, 4'hF);
    issue(1'b1, 1'b1, 32'h0000_0028, 32'h3333_3333, 4'hF);
    drain();

    // LATENCY=3, req held for three loads.
    b_req = 1'b1; b_wr = 1'b0; b_wstrb = 4'h0; b_addr = 32'h0000_0020;
    @(negedge clk);
    chk("hold_n0_addr_ok", {31'd0, b_addr_ok}, 32'd1);
    chk("hold_n0_data_ok", {31'd0, b_data_ok}, 32'd0);
    exp_b.push_back(model_b[int'(32'h8)]);
    @(posedge clk); #1; b_addr = 32'h0000_0024;
    @(negedge clk);
    chk("hold_n1_addr_ok", {31'd0, b_addr_ok}, 32'd1);
    exp_b.push_back(model_b[int'(32'h9)]);
    @(posedge clk); #1; b_addr = 32'h0000_0028;
    @(negedge clk);
    chk("hold_full_addr_ok", {31'd0, b_addr_ok}, 32'd0);
    chk("hold_n2_data_ok", {31'd0, b_data_ok}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_first_resp", {31'd0, b_data_ok}, 32'd1);
    chk("hold_retire_accept", {31'd0, b_addr_ok}, 32'd1);
    exp_b.push_back(model_b[int'(32'hA)]);
    @(posedge clk); #1; b_req = 1'b0;
    @(negedge clk);
    chk("hold_second_resp", {31'd0, b_data_ok}, 32'd1);
    @(negedge clk);
    chk("hold_gap", {31'd0, b_data_ok}, 32'd0);
    @(negedge clk);
    chk("hold_third_resp", {31'd0, b_data_ok}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset with two loads in flight.
    issue(1'b1, 1'b0, 32'h0000_0020, 32'd0, 4'h0);
    issue(1'b1, 1'b0, 32'h0000_0024, 32'd0, 4'h0);
    rstn_b = 1'b0;
    exp_b.delete();
    #1;
    chk("rst_data_ok", {31'd0, b_data_ok}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rstn_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_data_ok", {31'd0, b_data_ok}, 32'd0);
    end
    chk("post_rst_addr_ok", {31'd0, b_addr_ok}, 32'd1);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h0000_0024, 32'd0, 4'h0);
    drain();
    chk("post_rst_ram", model_b[int'(32'h9)], 32'h2222_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
